// File: rtl/vdot_pkg.sv
// Shared types and helpers for the streaming vector dot-product engine.
package vdot_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } vdot_state_e;

  // Widest accumulator the clip helper can classify.
  localparam int unsigned SatMaxW = 256;

  function automatic int unsigned vdot_acc_w(input int unsigned elem_w,
                                             input int unsigned max_len);
    return 2 * elem_w + $clog2(max_len);
  endfunction

  function automatic int unsigned vdot_len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Returns {over, under}: whether acc lies outside the signed res_w range.
  function automatic logic [1:0] vdot_clip_dir(input logic signed [SatMaxW-1:0] acc,
                                               input int unsigned res_w);
    logic signed [SatMaxW-1:0] hi;
    hi = (SatMaxW'(1) << (res_w - 1)) - SatMaxW'(1);
    return {acc > hi, acc < ~hi};
  endfunction

endpackage

// File: rtl/vdot_lane_tree.sv
// Masked per-lane multiply (S1) followed by a registered binary adder tree (S2).
module vdot_lane_tree
  import vdot_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned ACC_W  = 74
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [LANES*ELEM_W-1:0] a_i,
  input  logic [LANES*ELEM_W-1:0] b_i,
  output logic                    valid_o,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    busy_o
);

  localparam int unsigned ProdW = 2 * ELEM_W;
  localparam int unsigned Nodes = 2 * LANES - 1;

  logic signed [ProdW-1:0] prod_d [LANES];
  logic signed [ProdW-1:0] prod_q [LANES];
  logic signed [ACC_W-1:0] node   [Nodes];
  logic signed [ACC_W-1:0] sum_q;
  logic                    s1_valid_q;
  logic                    s2_valid_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = '0;
      if (mask_i[i]) begin
        prod_d[i] = ProdW'($signed(a_i[i*ELEM_W +: ELEM_W])) *
                    ProdW'($signed(b_i[i*ELEM_W +: ELEM_W]));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // Heap-ordered tree: leaves at LANES-1.., node n sums children 2n+1 and 2n+2.
  always_comb begin
    for (int i = 0; i < LANES; i++) node[LANES-1+i] = ACC_W'(prod_q[i]);
    for (int n = LANES - 2; n >= 0; n--) node[n] = node[2*n+1] + node[2*n+2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) sum_q <= node[0];
    end
  end

  assign valid_o = s2_valid_q;
  assign sum_o   = sum_q;
  assign busy_o  = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/vector_dot_engine.sv
// Streaming dot-product engine: chunked input, tail masking, pipelined accumulate.
// Define VDOT_SATURATE_EN to clamp the result to the signed RES_W range instead of wrapping.
module vector_dot_engine
  import vdot_pkg::*;
#(
  parameter int unsigned LANES   = 8,
  parameter int unsigned ELEM_W  = 32,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned ACC_W   = vdot_acc_w(ELEM_W, MAX_LEN),
  parameter int unsigned LEN_W   = vdot_len_w(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ELEM_W-1:0] in_a,
  input  logic [LANES*ELEM_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_result,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int unsigned LaneIdxW = $clog2(LANES);

  vdot_state_e             state_q, state_d;
  logic [LEN_W-1:0]        len_clamped;
  logic [LEN_W:0]          chunk_round;
  logic [LEN_W-1:0]        chunks_left_q, chunks_left_d;
  logic [LANES-1:0]        tail_mask_q, tail_mask_d;
  logic [LANES-1:0]        lane_mask;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] tree_sum;
  logic                    tree_valid;
  logic                    pipe_busy;
  logic                    job_start;
  logic                    xfer;
  logic                    last_chunk;
  logic [RES_W-1:0]        result_n;
  logic                    sat_n;

  // Job setup values derived from cfg_len.
  always_comb begin
    len_clamped   = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    chunk_round   = {1'b0, len_clamped} + (LEN_W+1)'(LANES - 1);
    chunks_left_d = LEN_W'(chunk_round >> LaneIdxW);
    for (int i = 0; i < LANES; i++) begin
      tail_mask_d[i] = (len_clamped[LaneIdxW-1:0] == '0) ||
                       (LaneIdxW'(i) < len_clamped[LaneIdxW-1:0]);
    end
  end

  assign job_start  = (state_q == StIdle) && start;
  assign xfer       = in_valid && in_ready;
  assign last_chunk = (chunks_left_q == LEN_W'(1));
  assign lane_mask  = last_chunk ? tail_mask_q : '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (len_clamped == '0) ? StDone : StLoad;
      StLoad:  if (xfer && last_chunk) state_d = StDrain;
      StDrain: if (!pipe_busy) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle:  busy      = 1'b0;
      StLoad:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (job_start)       acc_d = '0;
    else if (tree_valid) acc_d = acc_q + tree_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chunks_left_q <= '0;
      tail_mask_q   <= '0;
      acc_q         <= '0;
    end else begin
      acc_q <= acc_d;
      if (job_start) begin
        chunks_left_q <= chunks_left_d;
        tail_mask_q   <= tail_mask_d;
      end else if (xfer) begin
        chunks_left_q <= chunks_left_q - LEN_W'(1);
      end
    end
  end

  vdot_lane_tree #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .ACC_W  (ACC_W)
  ) u_lane_tree (
    .clk     (clk),
    .reset   (reset),
    .valid_i (xfer),
    .mask_i  (lane_mask),
    .a_i     (in_a),
    .b_i     (in_b),
    .valid_o (tree_valid),
    .sum_o   (tree_sum),
    .busy_o  (pipe_busy)
  );

  if (RES_W >= ACC_W) begin : g_wide
    assign result_n = RES_W'(acc_q);
    assign sat_n    = 1'b0;
  end else begin : g_narrow
`ifdef VDOT_SATURATE_EN
    logic [1:0] clip;
    assign clip = vdot_clip_dir(SatMaxW'(acc_q), RES_W);
    always_comb begin
      sat_n    = |clip;
      result_n = acc_q[RES_W-1:0];
      if (clip[1])      result_n = {1'b0, {(RES_W-1){1'b1}}};
      else if (clip[0]) result_n = {1'b1, {(RES_W-1){1'b0}}};
    end
`else
    assign result_n = acc_q[RES_W-1:0];
    assign sat_n    = 1'b0;
`endif
  end

  // Accumulator is frozen in DONE, so the result holds until the handshake.
  assign out_result = out_valid ? result_n : '0;
  assign out_sat    = out_valid & sat_n;

endmodule

// File: tb/tb_vector_dot_engine.sv
// Scoreboard bench for vector_dot_engine: expected results queued at job start, checked on handshake.
module tb_vector_dot_engine;

  localparam int unsigned LANES   = 8;
  localparam int unsigned ELEM_W  = 32;
  localparam int unsigned MAX_LEN = 1024;
  localparam int unsigned RES_W   = 32;
  localparam int unsigned LEN_W   = 11;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic [LEN_W-1:0]        cfg_len = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*ELEM_W-1:0] in_a = '0;
  logic [LANES*ELEM_W-1:0] in_b = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [RES_W-1:0]        out_result;
  logic                    out_sat;
  logic                    busy;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             sat;
  } exp_t;

  exp_t sb_q[$];
  int   va [MAX_LEN];
  int   vb [MAX_LEN];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vector_dot_engine #(
    .LANES   (LANES),
    .ELEM_W  (ELEM_W),
    .MAX_LEN (MAX_LEN),
    .RES_W   (RES_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int len);
    logic signed [127:0] acc;
    longint              p;
    exp_t                e;
    acc = '0;
    for (int i = 0; i < len; i++) begin
      p   = longint'(va[i]) * longint'(vb[i]);
      acc = acc + 128'(p);
    end
`ifdef VDOT_SATURATE_EN
    if (acc > 128'sh7FFFFFFF)        e = '{32'h7FFFFFFF, 1'b1};
    else if (acc < -128'sh80000000)  e = '{32'h80000000, 1'b1};
    else                             e = '{acc[31:0], 1'b0};
`else
    e = '{acc[31:0], 1'b0};
`endif
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_out_sat"}, out_sat, 0);
    check_eq({tag, "_out_result"}, out_result, 0);
  endtask

  task automatic start_job(input int len);
    int eff;
    eff = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
    sb_q.push_back(model(eff));
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("in_ready_after_start", in_ready, (eff != 0));
  endtask

  // Masked lanes carry garbage so a broken tail mask shows up in the sum.
  task automatic send_chunks(input int len, input int n_send, input bit bubbles);
    for (int c = 0; c < n_send; c++) begin
      if (bubbles && c > 0) begin
        in_valid = 1'b0;
        in_a     = '1;
        in_b     = '1;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      for (int l = 0; l < int'(LANES); l++) begin
        int idx;
        idx = c * int'(LANES) + l;
        in_a[l*ELEM_W +: ELEM_W] = (idx < len) ? va[idx] : 32'h7FFFFFFF;
        in_b[l*ELEM_W +: ELEM_W] = (idx < len) ? vb[idx] : 32'h7FFFFFFF;
      end
      check_eq("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, k, exp_lat);
  endtask

  task automatic finish_job(input int hold, input bit start_on_hs);
    exp_t             e;
    logic [RES_W-1:0] r0;
    r0 = out_result;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_result", out_result, r0);
      check_eq("hold_busy", busy, 1);
    end
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("result", out_result, e.result);
      check_eq("sat", out_sat, e.sat);
    end
    check_eq("valid_at_hs", out_valid, 1);
    out_ready = 1'b1;
    start     = start_on_hs;
    cfg_len   = LEN_W'(8);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq("busy_after_hs", busy, 0);
    check_eq("valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Exact chunks: sum(1..16) = 136
    for (int i = 0; i < 16; i++) begin va[i] = i + 1; vb[i] = 1; end
    start_job(16);
    send_chunks(16, 2, 1'b0);
    check_eq("exact_in_ready_drop", in_ready, 0);
    wait_result("exact_latency", 3);
    check_eq("exact_136", out_result, 136);
    finish_job(0, 1'b0);

    // Partial chunk: 10 lanes of 2*2 = 40, garbage on lanes 2..7 of chunk 2
    for (int i = 0; i < 10; i++) begin va[i] = 2; vb[i] = 2; end
    start_job(10);
    send_chunks(10, 2, 1'b0);
    wait_result("partial_latency", 3);
    check_eq("partial_40", out_result, 40);
    finish_job(0, 1'b0);

    // Bubbles and back-pressure: 24 * (-3 * 5) = -360; start during handshake ignored
    for (int i = 0; i < 24; i++) begin va[i] = -3; vb[i] = 5; end
    start_job(24);
    send_chunks(24, 3, 1'b1);
    wait_result("bubble_latency", 3);
    check_eq("bubble_neg360", out_result, 32'hFFFFFE98);
    finish_job(5, 1'b1);

    // len = 0: result 0 one edge after start
    start_job(0);
    wait_result("len0_latency", 0);
    check_eq("len0_result", out_result, 0);
    finish_job(0, 1'b0);

    // Length clamp: 2000 -> 1024 elements, 128 chunks
    for (int i = 0; i < int'(MAX_LEN); i++) begin va[i] = 1; vb[i] = 1; end
    start_job(2000);
    send_chunks(int'(MAX_LEN), 128, 1'b0);
    check_eq("clamp_in_ready_drop", in_ready, 0);
    wait_result("clamp_latency", 3);
    check_eq("clamp_1024", out_result, 1024);
    finish_job(0, 1'b0);

    // Saturation corner: 8 * 2^60 = 2^63
    for (int i = 0; i < 8; i++) begin va[i] = 32'h40000000; vb[i] = 32'h40000000; end
    start_job(8);
    send_chunks(8, 1, 1'b0);
    wait_result("sat_latency", 3);
`ifdef VDOT_SATURATE_EN
    check_eq("sat_clip_value", out_result, 32'h7FFFFFFF);
    check_eq("sat_flag", out_sat, 1);
`else
    check_eq("wrap_value", out_result, 0);
    check_eq("wrap_flag", out_sat, 0);
`endif
    finish_job(0, 1'b0);

    // Reset mid-job after 3 of 5 chunks
    for (int i = 0; i < 40; i++) begin va[i] = 1000 + i; vb[i] = 7; end
    start_job(40);
    send_chunks(40, 3, 1'b0);
    in_valid = 1'b1;
    reset    = 1'b0;
    #1;
    check_idle_outputs("midreset");
    sb_q.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin va[i] = i - 3; vb[i] = 2 * i + 1; end
    start_job(8);
    send_chunks(8, 1, 1'b0);
    wait_result("post_reset_latency", 3);
    finish_job(0, 1'b0);

    // Random jobs; in_valid held high with garbage while idle must not be consumed
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1;
      in_a     = '1;
      in_b     = '1;
      @(posedge clk); #1;
      check_eq("idle_in_ready", in_ready, 0);
      in_valid = 1'b0;
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin va[i] = $urandom; vb[i] = $urandom; end
      start_job(len);
      send_chunks(len, (len + int'(LANES) - 1) / int'(LANES), 1'($urandom_range(0, 1)));
      check_eq("rand_in_ready_drop", in_ready, 0);
      wait_result("rand_latency", 3);
      finish_job($urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
